// File: rtl/stopwatch_counter.sv
// Stopwatch time base: MM:SS BCD counter with a debounced pause toggle and a
// per-field adjust mode. The blink output flags the field being adjusted.
module stopwatch_counter #(
  parameter int TICK_DIV   = 100000000,
  parameter int ADJ_DIV    = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resett,
  input  logic       pause,
  input  logic       select,
  input  logic [1:0] adj,
  output logic [3:0] sec0cnt,
  output logic [3:0] sec1cnt,
  output logic [3:0] min0cnt,
  output logic [3:0] min1cnt,
  output logic       running,
  output logic       adjusting,
  output logic       blink
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ADJ_DIV > 2) ? $clog2(ADJ_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  // Bit order: 0 pause, 1 select, 2 adjust enable, 3 adjust direction
  logic [3:0] raw_vec;
  logic [3:0] sync_vec;
  assign raw_vec = {adj[1], adj[0], select, pause};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= raw_vec[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_vec[gi] = sync_reg;
    end
  endgenerate

  logic pause_s, sel_s, mode_s, dir_s;
  assign pause_s = sync_vec[0];
  assign sel_s   = sync_vec[1];
  assign mode_s  = sync_vec[2];
  assign dir_s   = sync_vec[3];

  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [AW-1:0] adj_cnt_reg, adj_cnt_next;
  logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
  logic          deb_level_reg, deb_level_next;
  logic          deb_prev_reg;
  logic          running_reg, running_next;
  logic          adjusting_reg;
  logic          blink_reg, blink_next;
  logic [7:0]    sec_reg, sec_next;   // {tens, ones}
  logic [7:0]    min_reg, min_next;

  logic tick, adj_tick, deb_rise;
  assign tick     = (tick_cnt_reg == TICK_LAST);
  assign adj_tick = (adj_cnt_reg == ADJ_LAST);
  assign deb_rise = deb_level_reg & ~deb_prev_reg;

  // One step of a two-digit BCD field that wraps 59 <-> 00.
  function automatic logic [7:0] bcd60_step(input logic [7:0] v, input logic down);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (!down) begin
      if (o == 4'd9) begin
        o = 4'd0;
        t = (t == 4'd5) ? 4'd0 : t + 4'd1;
      end else begin
        o = o + 4'd1;
      end
    end else begin
      if (o == 4'd0) begin
        o = 4'd9;
        t = (t == 4'd0) ? 4'd5 : t - 4'd1;
      end else begin
        o = o - 4'd1;
      end
    end
    return {t, o};
  endfunction

  always_comb begin
    tick_cnt_next  = tick ? '0 : tick_cnt_reg + 1'b1;
    adj_cnt_next   = adj_tick ? '0 : adj_cnt_reg + 1'b1;

    deb_cnt_next   = '0;
    deb_level_next = deb_level_reg;
    if (pause_s != deb_level_reg) begin
      if (deb_cnt_reg == DEB_LAST) begin
        deb_level_next = pause_s;
      end else begin
        deb_cnt_next = deb_cnt_reg + 1'b1;
      end
    end

    // A toggle and a tick in the same cycle: the tick sees the old running.
    running_next = running_reg ^ deb_rise;

    blink_next = 1'b0;
    sec_next   = sec_reg;
    min_next   = min_reg;
    if (adjusting_reg) begin
      blink_next = blink_reg ^ adj_tick;
      if (adj_tick) begin
        if (sel_s) begin
          sec_next = bcd60_step(sec_reg, dir_s);
        end else begin
          min_next = bcd60_step(min_reg, dir_s);
        end
      end
    end else if (tick && running_reg) begin
      sec_next = bcd60_step(sec_reg, 1'b0);
      if (sec_reg == 8'h59) begin
        min_next = bcd60_step(min_reg, 1'b0);
      end
    end
  end

  always_ff @(posedge clk or negedge resett) begin
    if (!resett) begin
      tick_cnt_reg  <= '0;
      adj_cnt_reg   <= '0;
      deb_cnt_reg   <= '0;
      deb_level_reg <= 1'b0;
      deb_prev_reg  <= 1'b0;
      running_reg   <= 1'b0;
      adjusting_reg <= 1'b0;
      blink_reg     <= 1'b0;
      sec_reg       <= 8'h00;
      min_reg       <= 8'h00;
    end else begin
      tick_cnt_reg  <= tick_cnt_next;
      adj_cnt_reg   <= adj_cnt_next;
      deb_cnt_reg   <= deb_cnt_next;
      deb_level_reg <= deb_level_next;
      deb_prev_reg  <= deb_level_reg;
      running_reg   <= running_next;
      adjusting_reg <= mode_s;
      blink_reg     <= blink_next;
      sec_reg       <= sec_next;
      min_reg       <= min_next;
    end
  end

  assign sec0cnt   = sec_reg[3:0];
  assign sec1cnt   = sec_reg[7:4];
  assign min0cnt   = min_reg[3:0];
  assign min1cnt   = min_reg[7:4];
  assign running   = running_reg;
  assign adjusting = adjusting_reg;
  // Gated so blink drops in the very cycle adjusting falls.
  assign blink     = blink_reg & adjusting_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboarded bench for stopwatch_counter: a time-in-seconds reference model
// pushes expected outputs each clock; a monitor pops and compares at negedge.
module tb_stopwatch_counter;

  localparam int TD = 10;
  localparam int AD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       resett;
  logic       pause;
  logic       select;
  logic [1:0] adj;
  logic [3:0] sec0cnt, sec1cnt, min0cnt, min1cnt;
  logic       running, adjusting, blink;

  stopwatch_counter #(.TICK_DIV(TD), .ADJ_DIV(AD), .DEB_CYCLES(DC)) dut (
    .clk(clk), .resett(resett), .pause(pause), .select(select), .adj(adj),
    .sec0cnt(sec0cnt), .sec1cnt(sec1cnt), .min0cnt(min0cnt), .min1cnt(min1cnt),
    .running(running), .adjusting(adjusting), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mm;
    int ss;
    bit run;
    bit adj;
    bit blink;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int to_cnt = 0;
  int to_seen = 0;

  // Reference model: time held as total seconds, adjust is modular arithmetic.
  int m_tot = 0, m_n = 0, m_dcnt = 0, mm_t, ss_t;
  bit m_run = 0, m_adj = 0, m_blink = 0, m_deb = 0, m_pend = 0;
  bit p_s1 = 0, p_s2 = 0, sel_s1 = 0, sel_s2 = 0;
  bit a0_s1 = 0, a0_s2 = 0, a1_s1 = 0, a1_s2 = 0;
  bit tk, at, n_run, n_pend, n_blink;
  exp_t mod_e;

  always @(posedge clk) begin
    if (!resett) begin
      m_tot = 0; m_n = 0; m_dcnt = 0;
      m_run = 0; m_adj = 0; m_blink = 0; m_deb = 0; m_pend = 0;
      p_s1 = 0; p_s2 = 0; sel_s1 = 0; sel_s2 = 0;
      a0_s1 = 0; a0_s2 = 0; a1_s1 = 0; a1_s2 = 0;
    end else begin
      tk = (m_n % TD) == TD - 1;
      at = (m_n % AD) == AD - 1;
      m_n++;
      mm_t = m_tot / 60;
      ss_t = m_tot % 60;
      n_blink = 0;
      if (m_adj) begin
        n_blink = m_blink ^ at;
        if (at) begin
          if (sel_s2) ss_t = (ss_t + (a1_s2 ? 59 : 1)) % 60;
          else        mm_t = (mm_t + (a1_s2 ? 59 : 1)) % 60;
        end
        m_tot = mm_t * 60 + ss_t;
      end else if (tk && m_run) begin
        m_tot = (m_tot + 1) % 3600;
      end
      n_run  = m_run ^ m_pend;
      n_pend = 0;
      if (p_s2 != m_deb) begin
        if (m_dcnt == DC - 1) begin
          m_deb  = p_s2;
          m_dcnt = 0;
          n_pend = p_s2;
        end else begin
          m_dcnt++;
        end
      end else begin
        m_dcnt = 0;
      end
      m_adj = a0_s2;
      m_run = n_run;
      m_pend = n_pend;
      m_blink = n_blink;
      p_s2 = p_s1;   p_s1 = pause;
      sel_s2 = sel_s1; sel_s1 = select;
      a0_s2 = a0_s1; a0_s1 = adj[0];
      a1_s2 = a1_s1; a1_s1 = adj[1];
    end
    mod_e.mm = m_tot / 60;
    mod_e.ss = m_tot % 60;
    mod_e.run = m_run;
    mod_e.adj = m_adj;
    mod_e.blink = m_blink & m_adj;
    q.push_back(mod_e);
  end

  // Monitor: compares at negedge; a reset falling while clk is high is the
  // asynchronous-reset case and is checked 1 ns later.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk or negedge resett);
      if (clk === 1'b1) begin
        #1;
        q.delete();
        total++;
        if ({sec0cnt, sec1cnt, min0cnt, min1cnt, running, adjusting, blink} !== 19'd0) begin
          bad++;
          $display("FAIL async_reset t=%0t got %0d%0d:%0d%0d run=%0b adj=%0b blink=%0b want 00:00 run=0 adj=0 blink=0",
                   $time, min1cnt, min0cnt, sec1cnt, sec0cnt, running, adjusting, blink);
        end
      end else begin
        if (to_cnt != to_seen) begin
          total++;
          bad++;
          $display("FAIL wait_bound t=%0t got timeouts=%0d want 0", $time, to_cnt - to_seen);
          to_seen = to_cnt;
        end
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          total++;
          if (sec0cnt !== 4'(mon_e.ss % 10) || sec1cnt !== 4'(mon_e.ss / 10) ||
              min0cnt !== 4'(mon_e.mm % 10) || min1cnt !== 4'(mon_e.mm / 10) ||
              running !== mon_e.run || adjusting !== mon_e.adj || blink !== mon_e.blink) begin
            bad++;
            if (bad <= 30)
              $display("FAIL scoreboard t=%0t got %0d%0d:%0d%0d run=%0b adj=%0b blink=%0b want %02d:%02d run=%0b adj=%0b blink=%0b",
                       $time, min1cnt, min0cnt, sec1cnt, sec0cnt, running, adjusting, blink,
                       mon_e.mm, mon_e.ss, mon_e.run, mon_e.adj, mon_e.blink);
          end
        end
      end
    end
  end

  // Every stimulus step ends 2 ns after a rising edge.
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    resett = 1'b0;
    cyc(2);
    resett = 1'b1;
  endtask

  task automatic press(input int hold);
    pause = 1'b1;
    cyc(hold);
    pause = 1'b0;
    cyc(8);
  endtask

  task automatic start_run();
    if (!m_run) press(6);
  endtask

  task automatic stop_run();
    if (m_run) press(6);
  endtask

  // Step one field up until it hits target; leaving adjust takes 3 edges,
  // which lands before the next adjust step.
  task automatic adjust_to(input bit sel, input int target);
    int cur;
    int k;
    cur = sel ? (m_tot % 60) : (m_tot / 60);
    if (cur != target) begin
      select = sel;
      adj = 2'b01;
      k = 0;
      while (k < 400) begin
        cyc(1);
        k++;
        cur = sel ? (m_tot % 60) : (m_tot / 60);
        if (cur == target) break;
      end
      if (k >= 400) to_cnt++;
      adj = 2'b00;
      cyc(8);
    end
  endtask

  initial begin
    int k;
    resett = 1'b0;
    pause = 1'b0;
    select = 1'b0;
    adj = 2'b00;
    cyc(3);
    resett = 1'b1;

    $display("step: idle after reset");
    cyc(100);

    $display("step: clean press, glitch, second press");
    press(10);
    cyc(20);
    press(2);
    cyc(10);
    press(10);
    cyc(30);

    $display("step: run 00:58 through 01:00");
    adjust_to(1'b0, 0);
    adjust_to(1'b1, 58);
    start_run();
    cyc(40);
    stop_run();

    $display("step: wrap 59:59");
    adjust_to(1'b0, 59);
    adjust_to(1'b1, 59);
    start_run();
    cyc(15);
    stop_run();

    $display("step: adjust seconds up from 12:58");
    adjust_to(1'b0, 12);
    adjust_to(1'b1, 58);
    select = 1'b1;
    adj = 2'b01;
    cyc(16);
    pause = 1'b1;
    cyc(5);
    pause = 1'b0;
    cyc(15);
    adj = 2'b00;
    cyc(20);
    stop_run();

    $display("step: adjust minutes down from 00:30");
    adjust_to(1'b0, 0);
    adjust_to(1'b1, 30);
    select = 1'b0;
    adj = 2'b11;
    pause = 1'b1;
    cyc(5);
    pause = 1'b0;
    cyc(6);
    adj = 2'b00;
    cyc(30);

    $display("step: pause toggle coinciding with tick");
    start_run();
    k = 0;
    while ((m_n % TD) != 4 && k < 30) begin
      cyc(1);
      k++;
    end
    if (k >= 30) to_cnt++;
    pause = 1'b1;
    cyc(8);
    pause = 1'b0;
    cyc(12);

    $display("step: reset mid-adjust and mid-count");
    adj = 2'b01;
    cyc(7);
    do_reset();
    adj = 2'b00;
    cyc(5);
    start_run();
    cyc(23);
    do_reset();
    cyc(5);

    $display("step: random stimulus");
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        do_reset();
      end else begin
        pause  = 1'($urandom_range(0, 1));
        select = 1'($urandom_range(0, 1));
        adj    = 2'($urandom_range(0, 3));
        cyc(int'($urandom_range(1, 25)));
      end
    end
    adj = 2'b00;
    pause = 1'b0;
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
